frost32_mem_arbiter: RTL and testbench
======================================

// Module: frost32_mem_arbiter
// PURPOSE
//  Shares the single byte-wide synchronous main memory between the Frost32 instruction-fetch port and data port.
//  Arbitrates round-robin and sequences each 8/16/32-bit access as 1/2/4 consecutive big-endian byte cycles.
//  Returns a one-cycle ack per transaction.
//  Sits between Frost32Cpu and main memory; replaces the testbench's direct array access.
// PARAMETERS
//  MEM_ADDR_W  24  byte-address width of main memory; higher CPU address bits are dropped
// PORTS
//  clk           in   1           single clock, all state on posedge
//  rst_n         in   1           asynchronous, active-low reset
//  ifetch_req    in   1           fetch request; always 32-bit read; held with ifetch_addr until ifetch_ack
//  ifetch_addr   in   32          fetch byte address
//  ifetch_ack    out  1           one-cycle pulse: ifetch_rdata valid
//  ifetch_rdata  out  32          fetched word; held until next ifetch_ack
//  data_req      in   1           data request; held with data_* inputs until data_ack
//  data_we       in   1           0 = read (DiatRead), 1 = write (DiatWrite)
//  data_size     in   2           0 = 8-bit, 1 = 16-bit, 2 = 32-bit, 3 = reserved
//  data_addr     in   32          data byte address
//  data_wdata    in   32          write data, right-aligned
//  data_ack      out  1           one-cycle pulse: transaction complete
//  data_rdata    out  32          read data, right-aligned, zero-extended; held until next data_ack
//  mem_en        out  1           memory byte access strobe
//  mem_we        out  1           memory byte write enable (qualified by mem_en)
//  mem_addr      out  MEM_ADDR_W  memory byte address
//  mem_wdata     out  8           memory write byte
//  mem_rdata     in   8           read byte; valid the cycle after its mem_en read
//  busy          out  1           high in any state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n = 0):
//   - state = IDLE; all outputs 0; both rdata registers 0; round-robin pointer favours data port first.
//   - An in-flight transaction is aborted; bytes already written stay written; no ack is issued.
//  FSM IDLE -> XFER -> CAPT -> RESP -> IDLE.
//   - IDLE: if any req, grant and latch addr/size/we/wdata.
//     - Both requesting: grant the port not granted last; the pointer updates on each grant.
//     - Size n bytes = 1/2/4; size 3 is treated as 4.
//   - XFER: n cycles, byte i = 0..n-1.
//     - mem_en = 1, mem_we = latched we.
//     - mem_addr = (addr + i) mod 2^MEM_ADDR_W; wraps all-ones -> 0.
//     - Write byte i = wdata[8*(n-1-i) +: 8] (big-endian, MSB first).
//   - CAPT: one cycle, mem_en = 0, to sample the last read byte.
//     - Read byte i is sampled the cycle after issue and shifted in MSB-first.
//   - RESP: one cycle.
//     - Pulse the granted port's ack; update that port's rdata register.
//     - The other port's outputs are unchanged.
//     - For a write, rdata is not updated.
//  Latency and throughput:
//   - req sampled in cycle 0 (IDLE) -> ack in cycle n+2: 8-bit = 3, 16-bit = 4, 32-bit = 6.
//   - Back-to-back: requester may keep req high with new operands the cycle after ack; next grant in the following IDLE cycle.
//   - One transaction in flight at a time; the non-granted req simply waits; no starvation (round-robin).
//  Boundary conditions:
//   - req dropped mid-transaction: illegal, but the transaction completes and ack still pulses.
//   - Address wrap inside a multi-byte access follows the mod rule; no error.
// CONFIGURATION
//  FROST32_MEM_ARB_ALIGN_CHECK_EN defined:
//   - Adds port data_err (out, 1); reset 0; valid with data_ack.
//   - Error condition: data_size = 3, 16-bit with addr[0] = 1, or 32-bit with addr[1:0] != 0.
//     -> No mem_en cycles; IDLE -> RESP directly (ack in cycle 1); data_err = 1; data_rdata unchanged.
//   - Fetch with ifetch_addr[1:0] != 0 is not checked.
//  Undefined: no data_err port; misaligned accesses are performed bytewise as above.
// TESTING
//  - Reset: rst_n low mid-XFER of a 32-bit write -> all outputs 0 within the same cycle; state IDLE; no ack.
//  - Fetch: mem[0x100..0x103] = 11 22 33 44; ifetch_req at 0x100 -> ifetch_ack in cycle 6; ifetch_rdata = 0x11223344.
//  - Data write: size 1, addr 0x20, wdata 0xBEEF -> mem[0x20] = BE, mem[0x21] = EF; data_ack in cycle 4.
//  - Data read: size 0, addr 0x21 -> data_rdata = 0x000000EF.
//  - Contention: both req asserted from reset -> data granted first, then fetch; alternates while both held.
//    - mem_en never asserted for both in one cycle.
//  - Wrap: 32-bit read at 0xFFFFFE (MEM_ADDR_W = 24) -> mem_addr FFFFFE, FFFFFF, 000000, 000001.
//    - With ALIGN_CHECK_EN: data_err = 1 in cycle 1, and no mem_en.

Source files
------------

// File: rtl/frost32_mem_arbiter.sv
// Round-robin arbiter sharing the byte-wide main memory between the Frost32 fetch and data ports.
// Define FROST32_MEM_ARB_ALIGN_CHECK_EN to add data_err and reject misaligned data accesses.
module frost32_mem_arbiter #(
   parameter int MEM_ADDR_W = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ifetch_req,
   input  logic [31:0]           ifetch_addr,
   output logic                  ifetch_ack,
   output logic [31:0]           ifetch_rdata,
   input  logic                  data_req,
   input  logic                  data_we,
   input  logic [1:0]            data_size,
   input  logic [31:0]           data_addr,
   input  logic [31:0]           data_wdata,
   output logic                  data_ack,
   output logic [31:0]           data_rdata,
`ifdef FROST32_MEM_ARB_ALIGN_CHECK_EN
   output logic                  data_err,
`endif
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [7:0]            mem_wdata,
   input  logic [7:0]            mem_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, XFER, CAPT, RESP} state_t;

   state_t                state;
   logic                  prefer_data;
   logic                  is_data;
   logic                  is_write;
   logic [1:0]            byte_idx;
   logic [1:0]            last_idx;
   logic [31:0]           wr_shift;
   logic [23:0]           rd_shift;
   logic                  rd_pending;

   logic                  grant_data;
   logic [1:0]            req_last;
   logic                  req_we;
   logic [MEM_ADDR_W-1:0] req_addr;
   logic [31:0]           req_wdata;
   logic                  req_err;
   logic                  unused_addr_bits;

   // Address bits above MEM_ADDR_W are intentionally dropped.
   assign unused_addr_bits = ^{ifetch_addr, data_addr};
   assign busy             = (state != IDLE);

   // Write data is pre-shifted so the first byte to send always sits in bits 31:24.
   always_comb begin
      grant_data = data_req & (~ifetch_req | prefer_data);
      req_last   = 2'd3;
      req_we     = 1'b0;
      req_addr   = ifetch_addr[MEM_ADDR_W-1:0];
      req_wdata  = 32'd0;
      if (grant_data) begin
         req_we   = data_we;
         req_addr = data_addr[MEM_ADDR_W-1:0];
         case (data_size)
            2'd0:    begin req_last = 2'd0; req_wdata = {data_wdata[7:0], 24'd0}; end
            2'd1:    begin req_last = 2'd1; req_wdata = {data_wdata[15:0], 16'd0}; end
            default: req_wdata = data_wdata;
         endcase
      end
   end

`ifdef FROST32_MEM_ARB_ALIGN_CHECK_EN
   assign req_err = grant_data & ((data_size == 2'd3) |
                                  ((data_size == 2'd1) & data_addr[0]) |
                                  ((data_size == 2'd2) & (data_addr[1:0] != 2'd0)));
`else
   assign req_err = 1'b0;
`endif

   // Read bytes arrive one cycle after issue; rd_pending marks the cycles that carry one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         prefer_data  <= 1'b1;
         is_data      <= 1'b0;
         is_write     <= 1'b0;
         byte_idx     <= 2'd0;
         last_idx     <= 2'd0;
         wr_shift     <= 32'd0;
         rd_shift     <= 24'd0;
         rd_pending   <= 1'b0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= 8'd0;
         ifetch_ack   <= 1'b0;
         ifetch_rdata <= 32'd0;
         data_ack     <= 1'b0;
         data_rdata   <= 32'd0;
`ifdef FROST32_MEM_ARB_ALIGN_CHECK_EN
         data_err     <= 1'b0;
`endif
      end else begin
         rd_pending <= mem_en & ~mem_we;
         if (rd_pending) rd_shift <= {rd_shift[15:0], mem_rdata};
         case (state)
            IDLE: begin
               if (ifetch_req | data_req) begin
                  is_data     <= grant_data;
                  prefer_data <= ~grant_data;
                  rd_shift    <= 24'd0;
                  if (req_err) begin
                     state    <= RESP;
                     data_ack <= 1'b1;
`ifdef FROST32_MEM_ARB_ALIGN_CHECK_EN
                     data_err <= 1'b1;
`endif
                  end else begin
                     state     <= XFER;
                     byte_idx  <= 2'd0;
                     last_idx  <= req_last;
                     is_write  <= req_we;
                     wr_shift  <= {req_wdata[23:0], 8'd0};
                     mem_en    <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= req_addr;
                     mem_wdata <= req_wdata[31:24];
                  end
               end
            end
            XFER: begin
               if (byte_idx == last_idx) begin
                  state  <= CAPT;
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
               end else begin
                  byte_idx  <= byte_idx + 2'd1;
                  mem_addr  <= mem_addr + MEM_ADDR_W'(1);
                  mem_wdata <= wr_shift[31:24];
                  wr_shift  <= {wr_shift[23:0], 8'd0};
               end
            end
            CAPT: begin
               state <= RESP;
               if (is_data) begin
                  data_ack <= 1'b1;
                  if (!is_write) data_rdata <= {rd_shift, mem_rdata};
               end else begin
                  ifetch_ack   <= 1'b1;
                  ifetch_rdata <= {rd_shift, mem_rdata};
               end
            end
            default: begin
               state      <= IDLE;
               ifetch_ack <= 1'b0;
               data_ack   <= 1'b0;
`ifdef FROST32_MEM_ARB_ALIGN_CHECK_EN
               data_err   <= 1'b0;
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frost32_mem_arbiter.sv
// Bench for frost32_mem_arbiter: directed vector table, reset/contention/wrap sequences,
// and random transactions checked against a byte-level memory model.
module tb_frost32_mem_arbiter;

   localparam int          AW    = 24;
   localparam logic [31:0] AMASK = (32'd1 << AW) - 32'd1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ifetch_req;
   logic [31:0]   ifetch_addr;
   logic          ifetch_ack;
   logic [31:0]   ifetch_rdata;
   logic          data_req;
   logic          data_we;
   logic [1:0]    data_size;
   logic [31:0]   data_addr;
   logic [31:0]   data_wdata;
   logic          data_ack;
   logic [31:0]   data_rdata;
`ifdef FROST32_MEM_ARB_ALIGN_CHECK_EN
   logic          data_err;
`endif
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata;
   logic          busy;

   frost32_mem_arbiter #(.MEM_ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_ack(ifetch_ack), .ifetch_rdata(ifetch_rdata),
      .data_req(data_req), .data_we(data_we), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
`ifdef FROST32_MEM_ARB_ALIGN_CHECK_EN
      .data_err(data_err),
`endif
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   logic [7:0]    phys_mem [int unsigned];
   logic [7:0]    ref_mem  [int unsigned];
   logic [AW-1:0] addr_q [$];
   int errors = 0, checks = 0;
   int en_count = 0, ack_d_cnt = 0, ack_f_cnt = 0, both_cnt = 0;
   int res_lat, res_en, res_own, res_other, q_base;
   logic res_err;
   logic [31:0] exp_fr, exp_dr;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;
   vec_t tbl [9];

   function automatic logic [7:0] physByte(int unsigned a);
      return phys_mem.exists(a) ? phys_mem[a] : 8'h00;
   endfunction

   function automatic logic [7:0] refByte(int unsigned a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   // Synchronous byte memory: read data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) phys_mem[32'(mem_addr)] = mem_wdata;
         else        mem_rdata <= physByte(32'(mem_addr));
      end
   end

   always @(negedge clk) begin
      if (mem_en) begin
         en_count++;
         addr_q.push_back(mem_addr);
      end
      if (data_ack) ack_d_cnt++;
      if (ifetch_ack) ack_f_cnt++;
      if (data_ack && ifetch_ack) both_cnt++;
   end

   function automatic int nBytes(logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] modelRead(logic [31:0] a, int n);
      logic [31:0] v = 32'd0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(refByte((a + 32'(i)) & AMASK));
      return v;
   endfunction

   function automatic logic [31:0] physRead(logic [31:0] a, int n);
      logic [31:0] v = 32'd0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(physByte((a + 32'(i)) & AMASK));
      return v;
   endfunction

   function automatic void modelWrite(logic [31:0] a, int n, logic [31:0] w);
      for (int i = 0; i < n; i++) ref_mem[(a + 32'(i)) & AMASK] = 8'((w >> (8 * (n - 1 - i))) & 32'hFF);
   endfunction

   function automatic logic [31:0] lowBytes(logic [31:0] w, int n);
      return (n == 4) ? w : (w & ((32'd1 << (8 * n)) - 32'd1));
   endfunction

   function automatic bit alignErr(logic [1:0] s, logic [31:0] a);
`ifdef FROST32_MEM_ARB_ALIGN_CHECK_EN
      return (s == 2'd3) || ((a % 32'(nBytes(s))) != 0);
`else
      return 1'b0 && (s == 2'd3) && (a == 32'd0);
`endif
   endfunction

   task automatic preload(input int unsigned a, input logic [7:0] b);
      phys_mem[a] = b;
      ref_mem[a]  = b;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Runs one transaction starting in an IDLE cycle; returns one cycle after the ack, back in IDLE.
   task automatic applyStimulus(input bit fetch, input logic we, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata);
      int en_base = en_count;
      int d_base  = ack_d_cnt;
      int f_base  = ack_f_cnt;
      bit seen    = 1'b0;
      q_base = addr_q.size();
      if (fetch) begin
         ifetch_addr = addr;
         ifetch_req  = 1'b1;
      end else begin
         data_we    = we;
         data_size  = size;
         data_addr  = addr;
         data_wdata = wdata;
         data_req   = 1'b1;
      end
      res_lat = 0;
      res_err = 1'b0;
      while (!seen && res_lat < 40) begin
         @(posedge clk); #1;
         res_lat++;
         seen = fetch ? ifetch_ack : data_ack;
      end
`ifdef FROST32_MEM_ARB_ALIGN_CHECK_EN
      res_err = data_err;
`endif
      ifetch_req = 1'b0;
      data_req   = 1'b0;
      @(posedge clk); #1;
      res_en    = en_count - en_base;
      res_own   = fetch ? (ack_f_cnt - f_base) : (ack_d_cnt - d_base);
      res_other = fetch ? (ack_d_cnt - d_base) : (ack_f_cnt - f_base);
   endtask

   task automatic checkTxn(input string name, input int exp_lat, input int exp_en);
      checkOutput({name, " latency"}, 32'(res_lat), 32'(exp_lat));
      checkOutput({name, " mem_en cycles"}, 32'(res_en), 32'(exp_en));
      checkOutput({name, " own ack pulses"}, 32'(res_own), 32'd1);
      checkOutput({name, " other ack pulses"}, 32'(res_other), 32'd0);
      checkOutput({name, " ifetch_rdata"}, ifetch_rdata, exp_fr);
      checkOutput({name, " data_rdata"}, data_rdata, exp_dr);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit          r_fetch, r_e, seen;
      logic        r_we;
      logic [1:0]  r_size;
      logic [31:0] r_addr, r_wdata, a_seen;
      logic [31:0] wrap_exp [4];
      int          r_n, lat, n_ack, d_base, f_base, b_base;
      int          ack_who [4];
      int          ack_cyc [4];
      int          exp_cyc [4];

      tbl[0] = '{1'b1, 2'd1, 32'h0000_0020, 32'h0000_BEEF, 32'h0000_0000, 4};
      tbl[1] = '{1'b0, 2'd0, 32'h0000_0021, 32'h0,         32'h0000_00EF, 3};
      tbl[2] = '{1'b0, 2'd1, 32'h0000_0020, 32'h0,         32'h0000_BEEF, 4};
      tbl[3] = '{1'b1, 2'd2, 32'h0000_0040, 32'hCAFE_F00D, 32'h0000_BEEF, 6};
      tbl[4] = '{1'b0, 2'd2, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 6};
      tbl[5] = '{1'b0, 2'd0, 32'h0000_0043, 32'h0,         32'h0000_000D, 3};
      tbl[6] = '{1'b1, 2'd0, 32'h0000_0041, 32'h1234_5677, 32'h0000_000D, 3};
      tbl[7] = '{1'b0, 2'd2, 32'h0000_0040, 32'h0,         32'hCA77_F00D, 6};
      tbl[8] = '{1'b0, 2'd1, 32'h0000_0042, 32'h0,         32'h0000_F00D, 4};
      wrap_exp = '{32'h00FF_FFFE, 32'h00FF_FFFF, 32'h0000_0000, 32'h0000_0001};
      exp_cyc  = '{3, 10, 14, 21};

      rst_n = 1'b0;
      ifetch_req = 1'b0; ifetch_addr = 32'd0;
      data_req = 1'b0; data_we = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
      exp_fr = 32'd0;
      exp_dr = 32'd0;
      preload(32'h100, 8'h11); preload(32'h101, 8'h22); preload(32'h102, 8'h33); preload(32'h103, 8'h44);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset ctrl", {27'd0, mem_en, mem_we, busy, ifetch_ack, data_ack}, 32'd0);
      checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
      checkOutput("reset rdata", ifetch_rdata | data_rdata, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] directed vector table");
      for (int i = 0; i < 9; i++) begin
         exp_dr = tbl[i].exp_rdata;
         if (tbl[i].we) modelWrite(tbl[i].addr, nBytes(tbl[i].size), tbl[i].wdata);
         applyStimulus(1'b0, tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wdata);
         checkTxn($sformatf("vec%0d", i), tbl[i].exp_lat, nBytes(tbl[i].size));
      end
      checkOutput("write 0x20/0x21 bytes", physRead(32'h20, 2), 32'h0000_BEEF);

      $display("[TB] request dropped mid-transaction");
      data_we = 1'b1; data_size = 2'd0; data_addr = 32'h30; data_wdata = 32'h0000_0099; data_req = 1'b1;
      @(posedge clk); #1;
      data_req = 1'b0;
      lat = 1; seen = 1'b0;
      while (!seen && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         seen = data_ack;
      end
      checkOutput("dropped req ack cycle", 32'(lat), 32'd3);
      @(posedge clk); #1;
      checkOutput("dropped req write", 32'(physByte(32'h30)), 32'h99);
      modelWrite(32'h30, 1, 32'h99);

      $display("[TB] instruction fetch");
      exp_fr = 32'h1122_3344;
      applyStimulus(1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'd0);
      checkTxn("fetch", 6, 4);

      $display("[TB] reset during a 32-bit write");
      data_we = 1'b1; data_size = 2'd2; data_addr = 32'h80; data_wdata = 32'hAABB_CCDD; data_req = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      checkOutput("pre-reset busy", 32'(busy), 32'd1);
      checkOutput("pre-reset mem_addr", 32'(mem_addr), 32'h82);
      d_base = ack_d_cnt; f_base = ack_f_cnt;
      rst_n = 1'b0;
      data_req = 1'b0;
      #1;
      checkOutput("async reset ctrl", {27'd0, mem_en, mem_we, busy, ifetch_ack, data_ack}, 32'd0);
      checkOutput("async reset mem bus", {mem_wdata, mem_addr}, 32'd0);
      checkOutput("async reset ifetch_rdata", ifetch_rdata, 32'd0);
      checkOutput("async reset data_rdata", data_rdata, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("aborted txn acks", 32'((ack_d_cnt - d_base) + (ack_f_cnt - f_base)), 32'd0);
      checkOutput("aborted txn partial write", physRead(32'h80, 4), 32'hAABB_0000);
      modelWrite(32'h80, 2, 32'h0000_AABB);
      exp_fr = 32'd0;
      exp_dr = 32'd0;

      $display("[TB] contention from reset");
      n_ack = 0; lat = 0; b_base = both_cnt;
      for (int i = 0; i < 4; i++) begin ack_who[i] = -1; ack_cyc[i] = -1; end
      ifetch_addr = 32'h100;
      data_we = 1'b0; data_size = 2'd0; data_addr = 32'h21;
      ifetch_req = 1'b1; data_req = 1'b1;
      while (n_ack < 4 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (data_ack && n_ack < 4) begin ack_who[n_ack] = 0; ack_cyc[n_ack] = lat; n_ack++; end
         if (ifetch_ack && n_ack < 4) begin ack_who[n_ack] = 1; ack_cyc[n_ack] = lat; n_ack++; end
      end
      ifetch_req = 1'b0; data_req = 1'b0;
      @(posedge clk); #1;
      checkOutput("contention ack count", 32'(n_ack), 32'd4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("contention grant %0d port", i), 32'(ack_who[i]), 32'(i % 2));
         checkOutput($sformatf("contention grant %0d cycle", i), 32'(ack_cyc[i]), 32'(exp_cyc[i]));
      end
      checkOutput("contention overlapping acks", 32'(both_cnt - b_base), 32'd0);
      exp_fr = 32'h1122_3344;
      exp_dr = 32'h0000_00EF;
      checkOutput("contention ifetch_rdata", ifetch_rdata, exp_fr);
      checkOutput("contention data_rdata", data_rdata, exp_dr);

      $display("[TB] address wrap");
      preload(32'hFF_FFFE, 8'h5A); preload(32'hFF_FFFF, 8'hA5); preload(32'h0, 8'h3C); preload(32'h1, 8'hC3);
`ifdef FROST32_MEM_ARB_ALIGN_CHECK_EN
      applyStimulus(1'b0, 1'b0, 2'd2, 32'h00FF_FFFE, 32'd0);
      checkTxn("wrap misaligned", 1, 0);
      checkOutput("wrap data_err", 32'(res_err), 32'd1);
`else
      exp_dr = 32'h5AA5_3CC3;
      applyStimulus(1'b0, 1'b0, 2'd2, 32'h00FF_FFFE, 32'd0);
      checkTxn("wrap", 6, 4);
      for (int i = 0; i < 4; i++) begin
         a_seen = (q_base + i < addr_q.size()) ? 32'(addr_q[q_base + i]) : 32'hDEAD_BEEF;
         checkOutput($sformatf("wrap mem_addr %0d", i), a_seen, wrap_exp[i]);
      end
`endif

      $display("[TB] random transactions against memory model");
      for (int k = 0; k < 60; k++) begin
         r_fetch = ($urandom_range(0, 3) == 0);
         r_we    = r_fetch ? 1'b0 : 1'($urandom);
         r_size  = r_fetch ? 2'd2 : 2'($urandom_range(0, 3));
         r_addr  = {8'($urandom), ($urandom_range(0, 4) == 0) ? (24'hFF_FFFC + 24'($urandom_range(0, 3)))
                                                              : (24'h00_0040 + 24'($urandom_range(0, 15)))};
         r_wdata = $urandom;
         r_n     = nBytes(r_size);
         r_e     = !r_fetch && alignErr(r_size, r_addr);
         if (!r_e) begin
            if (r_fetch)   exp_fr = modelRead(r_addr, 4);
            else if (r_we) modelWrite(r_addr, r_n, r_wdata);
            else           exp_dr = modelRead(r_addr, r_n);
         end
         applyStimulus(r_fetch, r_we, r_size, r_addr, r_wdata);
         checkTxn($sformatf("rand%0d", k), r_e ? 1 : r_n + 2, r_e ? 0 : r_n);
`ifdef FROST32_MEM_ARB_ALIGN_CHECK_EN
         if (!r_fetch) checkOutput($sformatf("rand%0d data_err", k), 32'(res_err), 32'(r_e));
`endif
         if (r_we && !r_e) checkOutput($sformatf("rand%0d written bytes", k), physRead(r_addr, r_n), lowBytes(r_wdata, r_n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
